// File: rtl/delay_line_pkg.sv
// Shared types and pointer arithmetic for the audio delay-line sequencer.
package delay_line_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    RUN     = 2'd2,
    WAIT_RD = 2'd3
  } state_t;

  // Wide enough for any supported ADDRESS_WIDTH; callers truncate the result.
  localparam int unsigned PTR_MAX_W = 16;

  function automatic logic [PTR_MAX_W-1:0] rd_addr(
    input logic [PTR_MAX_W-1:0] wptr,
    input logic [PTR_MAX_W-1:0] off
  );
    return wptr - off;
  endfunction

endpackage

// File: rtl/delay_ptr_gen.sv
// Write pointer with natural wrap, plus the read address OFFSET samples behind it.
module delay_ptr_gen
  import delay_line_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_adv,
  input  logic [ADDRESS_WIDTH-1:0] i_off,
  output logic [ADDRESS_WIDTH-1:0] o_wptr,
  output logic [ADDRESS_WIDTH-1:0] o_rd_addr
);

  logic [ADDRESS_WIDTH-1:0] r_wptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
    end else if (i_adv) begin
      r_wptr <= r_wptr + ADDRESS_WIDTH'(1);
    end
  end

  assign o_wptr    = r_wptr;
  assign o_rd_addr = ADDRESS_WIDTH'(rd_addr(PTR_MAX_W'(r_wptr), PTR_MAX_W'(i_off)));

endmodule

// File: rtl/delay_line_ctrl.sv
// Delay-line RAM sequencer: writes each mic sample, reads it back OFFSET ticks later.
// Optional echo mix (dry + delayed average) enabled by defining DELAY_ECHO_MIX_EN.
module delay_line_ctrl
  import delay_line_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 9,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     sample_tick,
  input  logic [DATA_WIDTH-1:0]    mic_signal,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  output logic                     ram_wr,
  output logic                     ram_rd,
  output logic [ADDRESS_WIDTH-1:0] ram_addr1,
  output logic [ADDRESS_WIDTH-1:0] ram_addr0,
  output logic [DATA_WIDTH-1:0]    ram_din,
  input  logic [DATA_WIDTH-1:0]    ram_dout0,
  output logic [DATA_WIDTH-1:0]    delayed_out,
  output logic                     out_valid,
  output logic                     filling
);

  state_t                   r_state, w_next;
  logic [ADDRESS_WIDTH-1:0] r_off_q, r_fill_cnt, w_fill_inc, w_wptr, w_rd_addr;
  logic [DATA_WIDTH-1:0]    r_dout, w_rd_data, w_silence;
  logic                     r_valid;
  logic [15:0]              r_dbg_drop;
  logic                     w_tick_ok, w_off_chg, w_fill_tick, w_run_tick, w_rd;

  assign w_tick_ok   = en && sample_tick && (r_state == FILL || r_state == RUN);
  assign w_off_chg   = w_tick_ok && (offset != r_off_q);
  assign w_fill_tick = w_tick_ok && !w_off_chg && (r_state == FILL);
  assign w_run_tick  = w_tick_ok && !w_off_chg && (r_state == RUN);
  // Zero offset is a bypass: reading would hit the address being written.
  assign w_rd        = w_run_tick && (r_off_q != '0);
  assign w_fill_inc  = (r_fill_cnt == '1) ? r_fill_cnt : r_fill_cnt + ADDRESS_WIDTH'(1);

`ifdef DELAY_ECHO_MIX_EN
  logic [DATA_WIDTH-1:0] r_mic_q;
  logic [DATA_WIDTH:0]   w_mix_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mic_q <= '0;
    end else if (w_tick_ok) begin
      r_mic_q <= mic_signal;
    end
  end

  assign w_mix_sum = {1'b0, r_mic_q} + {1'b0, ram_dout0};
  assign w_rd_data = DATA_WIDTH'(w_mix_sum >> 1);
  assign w_silence = mic_signal;
`else
  assign w_rd_data = ram_dout0;
  assign w_silence = '0;
`endif

  delay_ptr_gen #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_adv    (w_tick_ok),
    .i_off    (r_off_q),
    .o_wptr   (w_wptr),
    .o_rd_addr(w_rd_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!en) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = (offset == '0) ? RUN : FILL;
        FILL, RUN: begin
          if (sample_tick) begin
            if (offset != r_off_q) begin
              w_next = (offset == '0) ? RUN : FILL;
            end else if (r_state == FILL) begin
              if (w_fill_inc == r_off_q) w_next = RUN;
            end else if (r_off_q != '0) begin
              w_next = WAIT_RD;
            end
          end
        end
        WAIT_RD: w_next = RUN;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_off_q    <= '0;
      r_fill_cnt <= '0;
      r_dout     <= '0;
      r_valid    <= 1'b0;
      r_dbg_drop <= '0;
    end else begin
      // Read ticks are answered combinationally from WAIT_RD; every other tick via r_valid.
      r_valid <= w_tick_ok && !w_rd;
      if ((r_state == IDLE && en) || w_off_chg) begin
        r_off_q    <= offset;
        r_fill_cnt <= '0;
      end
      if (w_fill_tick) r_fill_cnt <= w_fill_inc;
      if (w_tick_ok && !w_rd) r_dout <= w_run_tick ? mic_signal : w_silence;
      if (r_state == WAIT_RD) r_dout <= w_rd_data;
      if (en && sample_tick && r_state == WAIT_RD && r_dbg_drop != '1) begin
        r_dbg_drop <= r_dbg_drop + 16'd1;
      end
    end
  end

  always_comb begin
    ram_wr      = w_tick_ok;
    ram_addr1   = w_tick_ok ? w_wptr : '0;
    ram_din     = w_tick_ok ? mic_signal : '0;
    ram_rd      = w_rd;
    ram_addr0   = w_rd ? w_rd_addr : '0;
    filling     = (r_state == FILL);
    out_valid   = r_valid || (r_state == WAIT_RD);
    delayed_out = (r_state == WAIT_RD) ? w_rd_data : r_dout;
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed self-checking bench for delay_line_ctrl with a registered-read RAM model.
module tb_delay_line_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, en, sample_tick;
  logic [7:0] mic_signal;
  logic [8:0] offset;
  logic       ram_wr, ram_rd;
  logic [8:0] ram_addr1, ram_addr0;
  logic [7:0] ram_din, ram_dout0, delayed_out;
  logic       out_valid, filling;

  logic [7:0] mem [512];

  int errs   = 0;
  int checks = 0;

  logic       s_wr, s_rd, s_fill, p_valid, p_fill;
  logic [8:0] s_a1, s_a0;
  logic [7:0] s_din, p_dout;

  delay_line_ctrl #(
    .ADDRESS_WIDTH(9),
    .DATA_WIDTH   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sample_tick(sample_tick),
    .mic_signal (mic_signal),
    .offset     (offset),
    .ram_wr     (ram_wr),
    .ram_rd     (ram_rd),
    .ram_addr1  (ram_addr1),
    .ram_addr0  (ram_addr0),
    .ram_din    (ram_din),
    .ram_dout0  (ram_dout0),
    .delayed_out(delayed_out),
    .out_valid  (out_valid),
    .filling    (filling)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr1] <= ram_din;
    if (ram_rd) ram_dout0 <= mem[ram_addr0];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; sample_tick = 1'b0; mic_signal = '0; offset = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Tick in one cycle, sample tick-cycle outputs, then sample the following cycle.
  task automatic do_tick(input logic [7:0] m);
    @(negedge clk);
    sample_tick = 1'b1; mic_signal = m;
    #1;
    s_wr = ram_wr; s_rd = ram_rd; s_a1 = ram_addr1; s_a0 = ram_addr0; s_din = ram_din;
    s_fill = filling;
    @(negedge clk);
    sample_tick = 1'b0;
    p_valid = out_valid; p_dout = delayed_out; p_fill = filling;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; sample_tick = 1'b1; mic_signal = 8'h77; offset = 9'd5;
    #1;
    checks++;
    if ({ram_wr, ram_rd, ram_addr1, ram_addr0, ram_din, delayed_out, out_valid, filling} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got wr=%b rd=%b a1=%0d a0=%0d din=%h dout=%h v=%b f=%b exp all 0",
               ram_wr, ram_rd, ram_addr1, ram_addr0, ram_din, delayed_out, out_valid, filling);
    end
    do_reset();
    sample_tick = 1'b1; mic_signal = 8'h33;
    #1;
    checks++;
    if (ram_wr !== 1'b0) begin
      errs++; $display("FAIL idle_no_write got=%b exp=0", ram_wr);
    end
    sample_tick = 1'b0;
  endtask

  task automatic test_ramp();
    do_reset();
    offset = 9'd4; en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      do_tick(8'(k));
      checks++;
      if (s_wr !== 1'b1 || s_a1 !== 9'(k - 1) || s_din !== 8'(k)) begin
        errs++; $display("FAIL ramp_write k=%0d got wr=%b a1=%0d din=%h exp 1 %0d %h", k, s_wr, s_a1, s_din, k - 1, k);
      end
      checks++;
      if (p_valid !== 1'b1) begin
        errs++; $display("FAIL ramp_valid k=%0d got=%b exp=1", k, p_valid);
      end
      if (k <= 4) begin
        checks++;
        if (s_rd !== 1'b0 || s_fill !== 1'b1 || p_dout !== 8'h00) begin
          errs++; $display("FAIL ramp_fill k=%0d got rd=%b fill=%b dout=%h exp 0 1 00", k, s_rd, s_fill, p_dout);
        end
      end else begin
        checks++;
        if (s_rd !== 1'b1 || s_a0 !== 9'(k - 5) || p_dout !== 8'(k - 4)) begin
          errs++; $display("FAIL ramp_delay k=%0d got rd=%b a0=%0d dout=%h exp 1 %0d %h", k, s_rd, s_a0, p_dout, k - 5, k - 4);
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    offset = 9'd3; en = 1'b1;
    for (int k = 1; k <= 520; k++) begin
      do_tick(8'(k));
      checks++;
      if (s_a1 !== 9'(k - 1)) begin
        errs++; $display("FAIL wrap_addr1 k=%0d got=%0d exp=%0d", k, s_a1, 9'(k - 1));
      end
      if (k > 3) begin
        checks++;
        if (s_rd !== 1'b1 || s_a0 !== 9'(k - 4) || p_dout !== 8'(k - 3)) begin
          errs++; $display("FAIL wrap_read k=%0d got rd=%b a0=%0d dout=%h exp 1 %0d %h", k, s_rd, s_a0, p_dout, 9'(k - 4), 8'(k - 3));
        end
      end
      if (k == 514) begin
        checks++;
        if (s_a1 !== 9'd1 || s_a0 !== 9'd510) begin
          errs++; $display("FAIL wrap_boundary got a1=%0d a0=%0d exp 1 510", s_a1, s_a0);
        end
      end
    end
  endtask

  task automatic test_bypass();
    do_reset();
    offset = 9'd0; en = 1'b1;
    do_tick(8'hA5);
    checks++;
    if (s_rd !== 1'b0 || s_wr !== 1'b1 || s_din !== 8'hA5) begin
      errs++; $display("FAIL bypass_ram got rd=%b wr=%b din=%h exp 0 1 a5", s_rd, s_wr, s_din);
    end
    checks++;
    if (p_valid !== 1'b1 || p_dout !== 8'hA5 || p_fill !== 1'b0) begin
      errs++; $display("FAIL bypass_out got v=%b dout=%h fill=%b exp 1 a5 0", p_valid, p_dout, p_fill);
    end
    do_tick(8'h3C);
    checks++;
    if (s_a1 !== 9'd1 || s_rd !== 1'b0 || p_dout !== 8'h3C) begin
      errs++; $display("FAIL bypass_second got a1=%0d rd=%b dout=%h exp 1 0 3c", s_a1, s_rd, p_dout);
    end
  endtask

  task automatic test_offset_change();
    do_reset();
    offset = 9'd4; en = 1'b1;
    for (int k = 1; k <= 6; k++) do_tick(8'(k));
    checks++;
    if (p_dout !== 8'd2) begin
      errs++; $display("FAIL chg_pre got=%h exp=02", p_dout);
    end
    offset = 9'd8;
    for (int k = 7; k <= 15; k++) begin
      do_tick(8'(k));
      checks++;
      if (s_wr !== 1'b1 || s_rd !== 1'b0 || p_valid !== 1'b1 || p_dout !== 8'h00) begin
        errs++; $display("FAIL chg_silence k=%0d got wr=%b rd=%b v=%b dout=%h exp 1 0 1 00", k, s_wr, s_rd, p_valid, p_dout);
      end
      checks++;
      if (p_fill !== (k < 15)) begin
        errs++; $display("FAIL chg_filling k=%0d got=%b exp=%b", k, p_fill, k < 15);
      end
    end
    do_tick(8'd16);
    checks++;
    if (s_rd !== 1'b1 || s_a0 !== 9'd7 || p_dout !== 8'd8) begin
      errs++; $display("FAIL chg_first got rd=%b a0=%0d dout=%h exp 1 7 08", s_rd, s_a0, p_dout);
    end
    do_tick(8'd17);
    checks++;
    if (p_dout !== 8'd9) begin
      errs++; $display("FAIL chg_second got=%h exp=09", p_dout);
    end
  endtask

  task automatic test_drop_and_disable();
    do_reset();
    offset = 9'd2; en = 1'b1;
    for (int k = 1; k <= 3; k++) do_tick(8'(k));
    @(negedge clk);
    sample_tick = 1'b1; mic_signal = 8'd4;
    @(negedge clk);
    mic_signal = 8'h99;
    #1;
    checks++;
    if (ram_wr !== 1'b0 || out_valid !== 1'b1 || delayed_out !== 8'd2) begin
      errs++; $display("FAIL drop_waitrd got wr=%b v=%b dout=%h exp 0 1 02", ram_wr, out_valid, delayed_out);
    end
    @(negedge clk);
    sample_tick = 1'b0;
    do_tick(8'd5);
    checks++;
    if (s_a1 !== 9'd4 || p_dout !== 8'd3) begin
      errs++; $display("FAIL drop_resume got a1=%0d dout=%h exp 4 03", s_a1, p_dout);
    end
    @(negedge clk);
    en = 1'b0; sample_tick = 1'b1; mic_signal = 8'h44;
    #1;
    checks++;
    if (ram_wr !== 1'b0 || ram_rd !== 1'b0) begin
      errs++; $display("FAIL disable_now got wr=%b rd=%b exp 0 0", ram_wr, ram_rd);
    end
    @(negedge clk);
    sample_tick = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || filling !== 1'b0) begin
      errs++; $display("FAIL disable_idle got v=%b fill=%b exp 0 0", out_valid, filling);
    end
    en = 1'b1;
    do_tick(8'd6);
    checks++;
    if (s_a1 !== 9'd5 || s_rd !== 1'b0 || p_fill !== 1'b1) begin
      errs++; $display("FAIL disable_retain got a1=%0d rd=%b fill=%b exp 5 0 1", s_a1, s_rd, p_fill);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    offset = 9'd2; en = 1'b1;
    for (int k = 1; k <= 37; k++) do_tick(8'(k));
    @(negedge clk);
    sample_tick = 1'b1; mic_signal = 8'h55;
    #1;
    checks++;
    if (ram_wr !== 1'b1 || ram_addr1 !== 9'd37) begin
      errs++; $display("FAIL midrun_pre got wr=%b a1=%0d exp 1 37", ram_wr, ram_addr1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_wr, ram_rd, ram_addr1, ram_addr0, ram_din, delayed_out, out_valid, filling} !== '0) begin
      errs++;
      $display("FAIL midrun_reset got wr=%b rd=%b a1=%0d a0=%0d din=%h dout=%h v=%b f=%b exp all 0",
               ram_wr, ram_rd, ram_addr1, ram_addr0, ram_din, delayed_out, out_valid, filling);
    end
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_tick(8'h11);
    checks++;
    if (s_a1 !== 9'd0 || s_wr !== 1'b1) begin
      errs++; $display("FAIL midrun_wptr got a1=%0d wr=%b exp 0 1", s_a1, s_wr);
    end
  endtask

`ifdef DELAY_ECHO_MIX_EN
  task automatic test_echo_mix();
    do_reset();
    offset = 9'd1; en = 1'b1;
    do_tick(8'hFF);
    checks++;
    if (p_dout !== 8'hFF) begin
      errs++; $display("FAIL echo_dry got=%h exp=ff", p_dout);
    end
    do_tick(8'h01);
    checks++;
    if (p_dout !== 8'h80) begin
      errs++; $display("FAIL echo_mix got=%h exp=80", p_dout);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef DELAY_ECHO_MIX_EN
    test_echo_mix();
`else
    test_ramp();
    test_wrap();
    test_bypass();
    test_offset_change();
    test_drop_and_disable();
    test_reset_mid_run();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
